decode_ctrl: RTL
================

# decode_ctrl

Instruction decode and sequencing controller for the LC3 core. It drives the fetch stage: it pulses `fetch_start`, and presents the opcode, PC offset, base-register value and condition-code inputs that fetch uses to compute the next PC. It latches the memory word returned for `addr_out` into the instruction register (IR). It tracks the N/Z/P condition codes from register writeback.

## Interface
Parameters:
- `MEM_LAT`, default 1: cycles from `fetch_start` to a valid `instr_in`; legal range 1..4.

Ports:
- `clk`  in  1  single system clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `run_in`  in  1  level; starts and keeps the instruction sequence running.
- `instr_in`  in  16  memory read data for the last fetched address.
- `wb_valid_in`  in  1  register writeback strobe from execute.
- `wb_data_in`  in  16  value being written back.
- `reg_data_in`  in  16  register-file read data for `base_addr_out`.
- `fetch_start`  out  1  one-cycle pulse telling fetch to advance the PC.
- `opCode_out`  out  4  IR[15:12].
- `offset_out`  out  9  IR[8:0].
- `br_nzp_out`  out  3  IR[11:9], the branch condition mask.
- `result_nzp_out`  out  3  condition-code register.
- `reg_out`  out  16  registered base-register value, used by JMP.
- `base_addr_out`  out  3  IR[8:6].
- `dr_addr_out`  out  3  IR[11:9].
- `halt_out`  out  1  sticky halt flag.
- `illegal_out`  out  1  sticky; set when opcode 4'b1101 is decoded.

## Operation
- The FSM has five states: IDLE, ISSUE, WAIT, LATCH, EXEC.
- IDLE: no activity. Moves to ISSUE when `run_in`=1.
- ISSUE: `fetch_start`=1 for exactly this cycle. IR-derived outputs stay stable. Next state is WAIT.
  - After reset IR=0, so the first issue presents BR with nzp=000. That branch is never taken, so fetch does PC+1.
- WAIT: counts MEM_LAT-1 cycles. With MEM_LAT=1 it lasts 0 cycles, i.e. ISSUE goes straight to LATCH.
- LATCH: IR <= `instr_in`; `reg_out` <= `reg_data_in`. Next state is EXEC.
- EXEC, writing opcodes (ADD 0001, AND 0101, NOT 1001, LD 0010, LDR 0110, LDI 1010, LEA 1110):
  - Holds until `wb_valid_in`=1.
  - On that edge the CC register is loaded with nzp(`wb_data_in`). Negative gives 100, zero gives 010, positive gives 001.
- EXEC, all other opcodes: lasts one cycle.
- Leaving EXEC: goes to ISSUE if `run_in`=1, else IDLE. IR is held in IDLE.
- `wb_valid_in` outside EXEC, or during EXEC of a non-writing opcode: ignored, CC unchanged.
- Opcode 1101: sets `illegal_out` and is sequenced as a one-cycle NOP.
- Deasserting `run_in` mid-instruction does not abort it; the sequence stops at the end of EXEC.

## Timing
- Reset values:
  - state IDLE, IR 0, counter 0.
  - `fetch_start` 0; `opCode_out`, `offset_out`, `br_nzp_out`, `base_addr_out`, `dr_addr_out` 0.
  - `result_nzp_out` 3'b010.
  - `reg_out` 0, `halt_out` 0, `illegal_out` 0.
- Reset asserted mid-operation returns everything to the values above immediately, without waiting for a clock edge.
- Minimum instruction period with MEM_LAT=1 is 3 cycles (ISSUE, LATCH, EXEC). Writing opcodes add their writeback wait.
- `instr_in` is sampled exactly MEM_LAT cycles after the `fetch_start` edge.
- A new CC value is visible on `result_nzp_out` the cycle after `wb_valid_in`. Fetch therefore sees it at the next ISSUE.
- `fetch_start` never asserts on two consecutive cycles.

## Configuration
- Macro `LC3_TRAP_HALT_EN`.
- Defined:
  - TRAP (1111) with IR[7:0]=8'h25 sets `halt_out` in EXEC and moves to IDLE.
  - ISSUE is blocked until reset, regardless of `run_in`.
- Undefined:
  - TRAP is a one-cycle NOP.
  - `halt_out` is tied to 0.

## Structure
- Shared package `lc3_pkg` holds:
  - the opcode localparams (OP_BR, OP_ADD, … OP_TRAP);
  - the state encoding;
  - the constants `CC_N`/`CC_Z`/`CC_P` and `TRAP_HALT`=8'h25.
- Sub-module `nzp_gen`: combinational, 16-bit input to 3-bit one-hot N/Z/P output. The same module is reused by execute.

## Test plan
- Reset, then release with `run_in`=0 for 5 cycles:
  - all outputs stay at their reset values, `result_nzp_out`=010;
  - `fetch_start` never rises.
- `run_in`=1, MEM_LAT=1, `instr_in`=16'h1261 (ADD R1,R1,#1), `wb_valid_in` pulsed with `wb_data_in`=16'h8000:
  - `fetch_start` pulses once;
  - `opCode_out`=0001 and `offset_out`=9'h061 from the cycle after LATCH;
  - `result_nzp_out`=100 the cycle after the writeback pulse.
- MEM_LAT=3, `instr_in`=16'h0E05 (BRnzp #5):
  - IR loads exactly 3 cycles after `fetch_start`;
  - `br_nzp_out`=111, `offset_out`=9'h005;
  - the next `fetch_start` follows one EXEC cycle later.
- JMP `instr_in`=16'hC1C0 with `reg_data_in`=16'h3000:
  - `base_addr_out`=3'b111 and `reg_out`=16'h3000 after LATCH.
- `LC3_TRAP_HALT_EN` defined, `instr_in`=16'hF025:
  - `halt_out`=1 and no further `fetch_start` for 20 cycles;
  - `rst_n` pulse clears it.
- `instr_in`=16'hD000:
  - `illegal_out`=1 and stays 1;
  - sequencing continues.

Source files
------------

// File: rtl/lc3_pkg.sv
// Shared LC3 definitions: opcodes, decode/sequencer state encoding and condition-code constants.
package lc3_pkg;

   localparam logic [3:0] OP_BR   = 4'b0000;
   localparam logic [3:0] OP_ADD  = 4'b0001;
   localparam logic [3:0] OP_LD   = 4'b0010;
   localparam logic [3:0] OP_ST   = 4'b0011;
   localparam logic [3:0] OP_JSR  = 4'b0100;
   localparam logic [3:0] OP_AND  = 4'b0101;
   localparam logic [3:0] OP_LDR  = 4'b0110;
   localparam logic [3:0] OP_STR  = 4'b0111;
   localparam logic [3:0] OP_RTI  = 4'b1000;
   localparam logic [3:0] OP_NOT  = 4'b1001;
   localparam logic [3:0] OP_LDI  = 4'b1010;
   localparam logic [3:0] OP_STI  = 4'b1011;
   localparam logic [3:0] OP_JMP  = 4'b1100;
   localparam logic [3:0] OP_RES  = 4'b1101;
   localparam logic [3:0] OP_LEA  = 4'b1110;
   localparam logic [3:0] OP_TRAP = 4'b1111;

   localparam logic [2:0] CC_N = 3'b100;
   localparam logic [2:0] CC_Z = 3'b010;
   localparam logic [2:0] CC_P = 3'b001;

   localparam logic [7:0] TRAP_HALT = 8'h25;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT,
      ST_LATCH,
      ST_EXEC
   } state_t;

   // Opcodes whose EXEC must wait for a register writeback (and update the CC register).
   function automatic logic writes_reg(input logic [3:0] op);
      return (op == OP_ADD) || (op == OP_AND) || (op == OP_NOT) || (op == OP_LD) ||
             (op == OP_LDR) || (op == OP_LDI) || (op == OP_LEA);
   endfunction

endpackage

// File: rtl/nzp_gen.sv
// Combinational N/Z/P classifier of a 16-bit two's-complement value (one-hot output).
module nzp_gen
   import lc3_pkg::*;
(
   input  logic [15:0] data,
   output logic [2:0]  nzp
);

   always_comb begin
      if (data[15])
         nzp = CC_N;
      else if (data == 16'd0)
         nzp = CC_Z;
      else
         nzp = CC_P;
   end

endmodule

// File: rtl/decode_ctrl.sv
// LC3 decode/sequencing controller: issues fetches, latches IR and base register, tracks N/Z/P.
// Optional TRAP x25 halt support is enabled by defining LC3_TRAP_HALT_EN.
module decode_ctrl
   import lc3_pkg::*;
#(
   parameter int MEM_LAT = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        run_in,
   input  logic [15:0] instr_in,
   input  logic        wb_valid_in,
   input  logic [15:0] wb_data_in,
   input  logic [15:0] reg_data_in,
   output logic        fetch_start,
   output logic [3:0]  opCode_out,
   output logic [8:0]  offset_out,
   output logic [2:0]  br_nzp_out,
   output logic [2:0]  result_nzp_out,
   output logic [15:0] reg_out,
   output logic [2:0]  base_addr_out,
   output logic [2:0]  dr_addr_out,
   output logic        halt_out,
   output logic        illegal_out
);

   // WAIT spans MEM_LAT-1 cycles; the counter stops at this value.
   localparam logic [1:0] WAIT_LAST = (MEM_LAT > 1) ? 2'(MEM_LAT - 2) : 2'd0;

   state_t      state_reg, state_next;
   logic [1:0]  cnt_reg, cnt_next;
   logic [15:0] ir_reg, ir_next;
   logic [15:0] base_reg, base_next;
   logic [2:0]  cc_reg, cc_next;
   logic        halt_reg, halt_next;
   logic        illegal_reg, illegal_next;
   logic [2:0]  wb_nzp;
   logic [3:0]  op;
   logic        trap_halt;

   assign op = ir_reg[15:12];

`ifdef LC3_TRAP_HALT_EN
   assign trap_halt = (op == OP_TRAP) && (ir_reg[7:0] == TRAP_HALT);
`else
   assign trap_halt = 1'b0;
`endif

   nzp_gen u_nzp (
      .data (wb_data_in),
      .nzp  (wb_nzp)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg   <= ST_IDLE;
         cnt_reg     <= '0;
         ir_reg      <= '0;
         base_reg    <= '0;
         cc_reg      <= CC_Z;
         halt_reg    <= 1'b0;
         illegal_reg <= 1'b0;
      end else begin
         state_reg   <= state_next;
         cnt_reg     <= cnt_next;
         ir_reg      <= ir_next;
         base_reg    <= base_next;
         cc_reg      <= cc_next;
         halt_reg    <= halt_next;
         illegal_reg <= illegal_next;
      end
   end

   always_comb begin
      state_next   = state_reg;
      cnt_next     = cnt_reg;
      ir_next      = ir_reg;
      base_next    = base_reg;
      cc_next      = cc_reg;
      halt_next    = halt_reg;
      illegal_next = illegal_reg;
      fetch_start  = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (run_in && !halt_reg)
               state_next = ST_ISSUE;
         end
         ST_ISSUE: begin
            fetch_start = 1'b1;
            cnt_next    = '0;
            state_next  = (MEM_LAT > 1) ? ST_WAIT : ST_LATCH;
         end
         ST_WAIT: begin
            if (cnt_reg == WAIT_LAST)
               state_next = ST_LATCH;
            else
               cnt_next = cnt_reg + 2'd1;
         end
         ST_LATCH: begin
            ir_next    = instr_in;
            base_next  = reg_data_in;
            state_next = ST_EXEC;
         end
         ST_EXEC: begin
            // Writing opcodes park here until their writeback arrives.
            if (!writes_reg(op) || wb_valid_in) begin
               if (writes_reg(op))
                  cc_next = wb_nzp;
               if (op == OP_RES)
                  illegal_next = 1'b1;
               if (trap_halt) begin
                  halt_next  = 1'b1;
                  state_next = ST_IDLE;
               end else begin
                  state_next = run_in ? ST_ISSUE : ST_IDLE;
               end
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   assign opCode_out     = ir_reg[15:12];
   assign offset_out     = ir_reg[8:0];
   assign br_nzp_out     = ir_reg[11:9];
   assign dr_addr_out    = ir_reg[11:9];
   assign base_addr_out  = ir_reg[8:6];
   assign result_nzp_out = cc_reg;
   assign reg_out        = base_reg;
   assign halt_out       = halt_reg;
   assign illegal_out    = illegal_reg;

endmodule
